// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Imported by the FSM top and the combinational iteration step.
package mdu_pkg;

  typedef enum logic {
    MDU_MULTU = 1'b0,
    MDU_DIVU  = 1'b1
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  localparam int MDU_WIDTH = 8;

  function automatic int mdu_cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

  localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_datapath.sv
// One iteration of shift-add multiply or restoring divide.
// Purely combinational; the caller owns every register.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] hi_w,
  input  logic [WIDTH-1:0] lo_w,
  input  logic [WIDTH-1:0] arg,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  // MULTU: lo_w holds the multiplier, consumed LSB first.
  // DIVU: lo_w holds the dividend, refilled with quotient bits.
  always_comb begin
    sum     = {1'b0, hi_w} + {1'b0, (lo_w[0] ? arg : '0)};
    shifted = {hi_w, lo_w[WIDTH-1]};
    ge      = (shifted >= {1'b0, arg});
    hi_nx   = sum[WIDTH:1];
    lo_nx   = {sum[0], lo_w[WIDTH-1:1]};
    if (op == MDU_DIVU) begin
      hi_nx = ge ? WIDTH'(shifted - {1'b0, arg})
                 : shifted[WIDTH-1:0];
      lo_nx = {lo_w[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU with HI/LO and MFHI/MFLO readback.
// start/busy/done lets the controller stall while an operation runs.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CNT_W = mdu_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] hi_w;
  logic [WIDTH-1:0] lo_w;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [CNT_W-1:0] cnt;

  mdu_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .op   (op_q),
    .hi_w (hi_w),
    .lo_w (lo_w),
    .arg  (arg_q),
    .hi_nx(hi_nx),
    .lo_nx(lo_nx)
  );

  assign wb_data = hilo_sel ? hi : lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= MDU_MULTU;
      arg_q       <= '0;
      hi_w        <= '0;
      lo_w        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            // arg_q: multiplicand for MULTU, divisor for DIVU
            op_q        <= mdu_op_e'(op);
            arg_q       <= op ? operand_b : operand_a;
            hi_w        <= '0;
            lo_w        <= op ? operand_a : operand_b;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          hi_w <= hi_nx;
          lo_w <= lo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi          <= hi_nx;
            lo          <= lo_nx;
            busy        <= 1'b0;
            done        <= 1'b1;
            div_by_zero <= (op_q == MDU_DIVU)
                           && (arg_q == '0);
            state       <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
